// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter.
// - gw_state_t: lifecycle of one interrupt source inside its gateway.
// - REG_*: word-aligned byte offsets of the software-visible registers.
// - ID_W: width of a source ID. ID 0 means "no source", and source i has ID i+1.
package irq_pkg;

  localparam int ID_W = 5;

  localparam logic [3:0] REG_PENDING = 4'h0;
  localparam logic [3:0] REG_ENABLE  = 4'h4;
  localparam logic [3:0] REG_TRIGGER = 4'h8;
  localparam logic [3:0] REG_CLAIM   = 4'hC;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PENDING    = 2'd1,
    IN_SERVICE = 2'd2
  } gw_state_t;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway.
// It latches one request and holds it until software claims it. The source
// then stays in service until software completes it. Requests that arrive
// while the source is pending or in service are dropped, because the gateway
// does not count them.
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   src         raw request line, already synchronous to clk
//   edge_mode   1 = rising-edge trigger, 0 = level trigger
//   claim       one-cycle pulse: the arbiter picked this source on a claim read
//   complete    one-cycle pulse: software wrote this source's ID to COMPLETE
//   pending     gateway is in PENDING
//   in_service  gateway is in IN_SERVICE
//   state_o     raw FSM state, for observation
module irq_gateway
  import irq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      src,
  input  logic      edge_mode,
  input  logic      claim,
  input  logic      complete,
  output logic      pending,
  output logic      in_service,
  output gw_state_t state_o
);

  gw_state_t state_q, state_d;
  logic      hist_q, hist_d;
  logic      req;

  always_comb begin
    state_d = state_q;
    // The history flop follows the line every cycle, whatever the state is,
    // so an edge is seen only as a transition after the gateway becomes idle.
    hist_d  = src;
    req     = edge_mode ? (src & ~hist_q) : src;
    unique case (state_q)
      IDLE:       if (req)      state_d = PENDING;
      PENDING:    if (claim)    state_d = IN_SERVICE;
      IN_SERVICE: if (complete) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
    end
  end

  assign pending    = (state_q == PENDING);
  assign in_service = (state_q == IN_SERVICE);
  assign state_o    = state_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter that sits between the SoC interrupt sources and the single
// external-interrupt input of the CPU.
// Each source has its own gateway. The top level holds the ENABLE and TRIGGER
// registers, the fixed-priority encoder (lowest index wins), the claim and
// complete decode, and the registered ex_interrupt output.
// Register port handshake: a cycle with reg_en=1 is one complete access.
// There is no back-pressure. A read returns its data in reg_rdata on the next
// cycle, and reg_rdata keeps that value until the next read.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   irq_src       request lines, one per source
//   reg_en        access strobe, one cycle per access
//   reg_we        1 = write, 0 = read
//   reg_addr      byte offset: 0x0 PENDING, 0x4 ENABLE, 0x8 TRIGGER, 0xC CLAIM/COMPLETE
//   reg_wdata     write data
//   reg_rdata     registered read data
//   ex_interrupt  registered request to the CPU
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             reg_en,
  input  logic             reg_we,
  input  logic [3:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             ex_interrupt
);

  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] trigger_q, trigger_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ex_q, ex_d;

  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   in_service;
  logic [N_SRC-1:0]   claim_vec;
  logic [N_SRC-1:0]   complete_vec;
  logic [N_SRC-1:0]   cand;
  logic [2*N_SRC-1:0] gw_state_dbg;

  logic            rd_strobe;
  logic            wr_strobe;
  logic            claim_rd;
  logic            complete_wr;
  logic [ID_W-1:0] claim_id;
  logic [ID_W-1:0] complete_id;

  assign rd_strobe   = reg_en & ~reg_we;
  assign wr_strobe   = reg_en &  reg_we;
  assign claim_rd    = rd_strobe & (reg_addr == REG_CLAIM);
  assign complete_wr = wr_strobe & (reg_addr == REG_CLAIM);
  assign complete_id = reg_wdata[ID_W-1:0];

  // A masked source can still be pending. It is not a candidate until it is
  // enabled.
  assign cand = pending & enable_q;

  // Fixed priority. The loop scans downward, so the lowest set index writes last and wins.
  always_comb begin
    claim_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) claim_id = ID_W'(i + 1);
    end
  end

  // Claim and complete pulses to the gateways. A claim that returns ID 0
  // matches no source, so it has no side effects. A complete with an
  // out-of-range ID, or for a source that is not in service, is dropped here.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_vec[i]    = claim_rd & (claim_id == ID_W'(i + 1));
      complete_vec[i] = complete_wr & in_service[i] &
                        (complete_id == ID_W'(i + 1));
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk        (clk),
      .rst        (rst),
      .src        (irq_src[g]),
      .edge_mode  (trigger_q[g]),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g]),
      .state_o    (gw_state_dbg[2*g +: 2])
    );
  end

  // Register file and read path. The gateways use the registered ENABLE and
  // TRIGGER values, so a write to either register takes effect on the next cycle.
  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    rdata_d   = rdata_q;
    ex_d      = |cand;

    if (wr_strobe) begin
      unique case (reg_addr)
        REG_ENABLE:  enable_d  = reg_wdata[N_SRC-1:0];
        REG_TRIGGER: trigger_d = reg_wdata[N_SRC-1:0];
        default:     ;
      endcase
    end

    if (rd_strobe) begin
      unique case (reg_addr)
        REG_PENDING: rdata_d = 32'(pending);
        REG_ENABLE:  rdata_d = 32'(enable_q);
        REG_TRIGGER: rdata_d = 32'(trigger_q);
        REG_CLAIM:   rdata_d = 32'(claim_id);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q  <= '0;
      trigger_q <= '0;
      rdata_q   <= '0;
      ex_q      <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      trigger_q <= trigger_d;
      rdata_q   <= rdata_d;
      ex_q      <= ex_d;
    end
  end

  assign reg_rdata    = rdata_q;
  assign ex_interrupt = ex_q;

  // The upper write-data bits and the gateway state bus have no consumer
  // inside the arbiter.
  logic unused_bits;
  assign unused_bits = ^{reg_wdata, gw_state_dbg};

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_src;
  logic         reg_en;
  logic         reg_we;
  logic [3:0]   reg_addr;
  logic [31:0]  reg_wdata;
  logic [31:0]  reg_rdata;
  logic         ex_interrupt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  irq_arbiter #(.N_SRC(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .reg_en       (reg_en),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .ex_interrupt (ex_interrupt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural model. The sources are kept as sets: those waiting for a claim
  // and those being serviced.
  logic [N-1:0] m_pend, m_insvc, m_hist, m_en, m_trig;
  logic         m_ex;
  logic [31:0]  m_rd;

  always @(posedge clk) begin
    logic [N-1:0] cand, n_pend, n_insvc, n_en, n_trig;
    int id;
    if (rst) begin
      m_pend = '0; m_insvc = '0; m_hist = '0; m_en = '0; m_trig = '0;
      m_ex = 1'b0; m_rd = '0;
    end else begin
      cand    = m_pend & m_en;
      n_pend  = m_pend;
      n_insvc = m_insvc;
      n_en    = m_en;
      n_trig  = m_trig;
      if (reg_en && !reg_we) begin
        case (reg_addr)
          4'h0: m_rd = 32'(m_pend);
          4'h4: m_rd = 32'(m_en);
          4'h8: m_rd = 32'(m_trig);
          4'hC: begin
            id = 0;
            for (int i = 0; i < N; i++) if (id == 0 && cand[i]) id = i + 1;
            if (id != 0) begin
              n_pend[id-1]  = 1'b0;
              n_insvc[id-1] = 1'b1;
            end
            m_rd = 32'(id);
          end
          default: m_rd = '0;
        endcase
      end
      if (reg_en && reg_we) begin
        case (reg_addr)
          4'h4: n_en   = reg_wdata[N-1:0];
          4'h8: n_trig = reg_wdata[N-1:0];
          4'hC: begin
            id = int'(reg_wdata[4:0]);
            if (id >= 1 && id <= N && m_insvc[id-1]) n_insvc[id-1] = 1'b0;
          end
          default: ;
        endcase
      end
      // Only a source that is neither waiting nor being serviced can accept a new request.
      for (int i = 0; i < N; i++) begin
        if (!m_pend[i] && !m_insvc[i]) begin
          if (m_trig[i] ? (irq_src[i] && !m_hist[i]) : irq_src[i]) n_pend[i] = 1'b1;
        end
      end
      m_ex    = |cand;
      m_hist  = irq_src;
      m_pend  = n_pend;
      m_insvc = n_insvc;
      m_en    = n_en;
      m_trig  = n_trig;
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks the DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ex_interrupt_model", {31'd0, ex_interrupt}, {31'd0, m_ex});
      check("reg_rdata_model", reg_rdata, m_rd);
    end
  end

  // Driver tasks. Each one starts just after a negedge and ends on a negedge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
    reg_en = 1'b1; reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
    @(negedge clk);
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = addr;
    @(negedge clk);
    reg_en = 1'b0;
    check(name, reg_rdata, exp);
  endtask

  task automatic check_ex(input logic exp, input string name);
    check(name, {31'd0, ex_interrupt}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; reg_en = 1'b0; reg_we = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    check_ex(1'b0, "reset_ex");
    check("reset_rdata", reg_rdata, 32'h0);
    reg_read(4'h4, 32'h0, "reset_enable");
    reg_read(4'h8, 32'h0, "reset_trigger");

    // 1: level source, claim, then complete while the line is still high
    reg_write(4'h4, 32'h08);
    irq_src = 8'h08;
    cyc(1);
    check_ex(1'b0, "t1_ex_t1");
    cyc(1);
    check_ex(1'b1, "t1_ex_t2");
    reg_read(4'h0, 32'h08, "t1_pending");
    reg_read(4'hC, 32'd4, "t1_claim");
    check_ex(1'b1, "t1_ex_c1");
    cyc(1);
    check_ex(1'b0, "t1_ex_c2");
    reg_write(4'hC, 32'd4);
    cyc(2);
    check_ex(1'b1, "t1_ex_repend");
    reg_read(4'h0, 32'h08, "t1_repend");
    irq_src = '0;
    reg_read(4'hC, 32'd4, "t1_claim2");
    reg_write(4'hC, 32'd4);
    cyc(2);
    check_ex(1'b0, "t1_ex_idle");

    // 2: two sources rise together; the lower index wins
    reg_write(4'h4, 32'hFF);
    irq_src = 8'h24;
    cyc(1);
    irq_src = '0;
    cyc(1);
    reg_read(4'hC, 32'd3, "t2_claim_a");
    reg_read(4'hC, 32'd6, "t2_claim_b");
    cyc(1);
    check_ex(1'b0, "t2_ex_low");
    reg_read(4'hC, 32'd0, "t2_claim_none");
    reg_write(4'hC, 32'd3);
    reg_write(4'hC, 32'd6);

    // 3: edge mode; a second pulse while in service is dropped
    reg_write(4'h8, 32'h02);
    reg_write(4'h4, 32'h02);
    irq_src = 8'h02;
    cyc(1);
    irq_src = '0;
    cyc(2);
    reg_read(4'hC, 32'd2, "t3_claim");
    irq_src = 8'h02;
    cyc(1);
    irq_src = '0;
    cyc(1);
    reg_write(4'hC, 32'd2);
    cyc(2);
    reg_read(4'h0, 32'h0, "t3_pending");
    check_ex(1'b0, "t3_ex");
    reg_write(4'h8, 32'h0);

    // 4: pending but masked, then enabled
    reg_write(4'h4, 32'h0);
    irq_src = 8'h01;
    cyc(2);
    reg_read(4'h0, 32'h01, "t4_pending");
    check_ex(1'b0, "t4_ex_masked");
    reg_read(4'hC, 32'd0, "t4_claim_masked");
    reg_read(4'h0, 32'h01, "t4_pending_kept");
    irq_src = '0;
    reg_write(4'h4, 32'h01);
    check_ex(1'b0, "t4_ex_w1");
    cyc(1);
    check_ex(1'b1, "t4_ex_w2");
    reg_read(4'hC, 32'd1, "t4_claim");
    reg_write(4'hC, 32'd1);

    // 5: bogus completes, no re-pend while in service, reset mid-service
    reg_write(4'h4, 32'h08);
    irq_src = 8'h08;
    cyc(2);
    reg_read(4'hC, 32'd4, "t5_claim");
    reg_write(4'hC, 32'd7);
    reg_write(4'hC, 32'd0);
    cyc(2);
    reg_read(4'h0, 32'h0, "t5_no_repend");
    check_ex(1'b0, "t5_ex");
    rst = 1'b1; irq_src = '0;
    cyc(1);
    rst = 1'b0;
    check_ex(1'b0, "t5_rst_ex");
    check("t5_rst_rdata", reg_rdata, 32'h0);
    reg_read(4'h4, 32'h0, "t5_rst_enable");
    reg_read(4'h0, 32'h0, "t5_rst_pending");
    reg_read(4'hC, 32'd0, "t5_rst_claim");

    // randomized phase; the compare process checks every cycle against the model
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
      reg_en = ($urandom_range(0, 2) == 0);
      reg_we = $urandom_range(0, 1);
      reg_addr = 4'($urandom_range(0, 3) << 2);
      if (reg_addr == 4'hC) reg_wdata = 32'($urandom_range(0, 10));
      else reg_wdata = $urandom | $urandom;
      @(negedge clk);
    end
    rst = 1'b0; reg_en = 1'b0; reg_we = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
